// File: rtl/router_pkg.sv
// Shared router definitions: widths, header field layout and controller FSM encodings.
package router_pkg;

    localparam int ROUTER_DW    = 8;
    localparam int ROUTER_LW    = 6;

    // Header byte = {len, addr}
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_W   = 2;
    localparam int HDR_LEN_LSB  = HDR_ADDR_LSB + HDR_ADDR_W;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } router_state_t;

    function automatic logic [ROUTER_LW-1:0] hdr_len(input logic [ROUTER_DW-1:0] hdr);
        return hdr[HDR_LEN_LSB +: ROUTER_LW];
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR accumulator with synchronous clear (clear wins over enable).
module router_parity_acc #(
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] acc
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)    acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= acc ^ din;
    end

endmodule

// File: rtl/router_reg.sv
// Router datapath register block: header/hold capture, FIFO byte steering,
// payload count and parity/length error detection.
module router_reg
    import router_pkg::*;
#(
    parameter int DW = ROUTER_DW,
    parameter int LW = ROUTER_LW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          pkt_valid,
    input  logic [DW-1:0] data_in,
    input  logic          fifo_full,
    input  logic          detect_add,
    input  logic          lfd_state,
    input  logic          ld_state,
    input  logic          laf_state,
    input  logic          full_state,
    input  logic          rst_int_reg,
    output logic [DW-1:0] dout,
    output logic          parity_done,
    output logic          low_pkt_valid,
    output logic          err
);

    logic [DW-1:0] hdr_reg, hold_reg, pkt_parity, int_parity, acc_din;
    logic [LW-1:0] pay_cnt;
    logic          hold_pay, acc_en, parity_done_d, mismatch;

    // Header and the byte held back while the FIFO was full
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hdr_reg  <= '0;
            hold_reg <= '0;
            hold_pay <= 1'b0;
        end else begin
            if (detect_add && pkt_valid) hdr_reg <= data_in;
            if (ld_state && fifo_full) begin
                hold_reg <= data_in;
                hold_pay <= pkt_valid;
            end
        end
    end

    // full_state and any unlisted state fall through and hold dout
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                         dout <= '0;
        else if (lfd_state)                dout <= hdr_reg;
        else if (ld_state && !fifo_full)   dout <= data_in;
        else if (laf_state)                dout <= hold_reg;
    end

    always_comb begin
        acc_en  = 1'b0;
        acc_din = '0;
        if (lfd_state) begin
            acc_en  = 1'b1;
            acc_din = hdr_reg;
        end else if (ld_state && pkt_valid && !fifo_full) begin
            acc_en  = 1'b1;
            acc_din = data_in;
        end else if (laf_state && hold_pay) begin
            acc_en  = 1'b1;
            acc_din = hold_reg;
        end
    end

    router_parity_acc #(.DW(DW)) u_parity_acc (
        .clock (clock),
        .reset (reset),
        .clr   (detect_add),
        .en    (acc_en),
        .din   (acc_din),
        .acc   (int_parity)
    );

    // Payload bytes count even when diverted to hold_reg
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                        pay_cnt <= '0;
        else if (detect_add)                              pay_cnt <= '0;
        else if (ld_state && pkt_valid && pay_cnt != '1)  pay_cnt <= pay_cnt + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_parity    <= '0;
            low_pkt_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            pkt_parity    <= data_in;
            low_pkt_valid <= 1'b1;
        end else if (rst_int_reg) begin
            low_pkt_valid <= 1'b0;
        end
    end

    assign mismatch = (int_parity != pkt_parity) ||
                      (pay_cnt != hdr_reg[HDR_LEN_LSB +: LW]);

    // err samples the checks on the cycle after parity_done rises; it is
    // cleared on every detect_add so it can never outlive parity_done
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_done   <= 1'b0;
            parity_done_d <= 1'b0;
            err           <= 1'b0;
        end else begin
            parity_done_d <= parity_done;
            if (detect_add)
                parity_done <= 1'b0;
            else if ((ld_state && !fifo_full && !pkt_valid) ||
                     (laf_state && low_pkt_valid && !parity_done))
                parity_done <= 1'b1;
            if (detect_add)
                err <= 1'b0;
            else if (parity_done && !parity_done_d)
                err <= mismatch;
        end
    end

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: drives controller state decodes cycle by cycle.
module tb_router_reg;
    import router_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid, fifo_full;
    logic [7:0] data_in;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic [7:0] dout;
    logic       parity_done, low_pkt_valid, err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    router_reg dut (
        .clock        (clock),
        .reset        (reset),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .rst_int_reg  (rst_int_reg),
        .dout         (dout),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .err          (err)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply one cycle of controller state + inputs, then sample 1ns after the edge
    task automatic cyc(input router_state_t st, input logic pv, input logic [7:0] d,
                       input logic ff);
        detect_add  = (st == DECODE_ADDRESS);
        lfd_state   = (st == LOAD_FIRST_DATA);
        ld_state    = (st == LOAD_DATA) || (st == LOAD_PARITY);
        laf_state   = (st == LOAD_AFTER_FULL);
        full_state  = (st == FIFO_FULL_STATE);
        rst_int_reg = (st == CHECK_PARITY_ERROR);
        pkt_valid   = pv;
        data_in     = d;
        fifo_full   = ff;
        @(posedge clock);
        #1;
    endtask

    task automatic start_pkt(input logic [7:0] hdr);
        cyc(DECODE_ADDRESS, 1'b1, hdr, 1'b0);
        cyc(LOAD_FIRST_DATA, 1'b1, 8'h00, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        cyc(WAIT_TILL_EMPTY, 1'b0, 8'h00, 1'b0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_pd", 8'(parity_done), 8'h00);
        chk("rst_lpv", 8'(low_pkt_valid), 8'h00);
        chk("rst_err", 8'(err), 8'h00);
        reset = 1'b0;
        cyc(WAIT_TILL_EMPTY, 1'b0, 8'h00, 1'b0);

        // Good packet: hdr 0x0D, payload 11 22 33, parity 0D
        start_pkt(8'h0D);
        chk("p1_hdr", dout, 8'h0D);
        cyc(LOAD_DATA, 1'b1, 8'h11, 1'b0); chk("p1_d0", dout, 8'h11);
        cyc(LOAD_DATA, 1'b1, 8'h22, 1'b0); chk("p1_d1", dout, 8'h22);
        chk("p1_pd_early", 8'(parity_done), 8'h00);
        cyc(LOAD_DATA, 1'b1, 8'h33, 1'b0); chk("p1_d2", dout, 8'h33);
        cyc(LOAD_PARITY, 1'b0, 8'h0D, 1'b0);
        chk("p1_par", dout, 8'h0D);
        chk("p1_pd", 8'(parity_done), 8'h01);
        chk("p1_lpv", 8'(low_pkt_valid), 8'h01);
        cyc(CHECK_PARITY_ERROR, 1'b0, 8'h00, 1'b0);
        chk("p1_err", 8'(err), 8'h00);
        chk("p1_lpv_clr", 8'(low_pkt_valid), 8'h00);

        // Bad parity byte 0xFF: err exactly one cycle after parity_done
        start_pkt(8'h0D);
        cyc(LOAD_DATA, 1'b1, 8'h11, 1'b0);
        cyc(LOAD_DATA, 1'b1, 8'h22, 1'b0);
        cyc(LOAD_DATA, 1'b1, 8'h33, 1'b0);
        cyc(LOAD_PARITY, 1'b0, 8'hFF, 1'b0);
        chk("p2_pd", 8'(parity_done), 8'h01);
        chk("p2_err_t0", 8'(err), 8'h00);
        cyc(CHECK_PARITY_ERROR, 1'b0, 8'h00, 1'b0);
        chk("p2_err_t1", 8'(err), 8'h01);
        cyc(WAIT_TILL_EMPTY, 1'b0, 8'h00, 1'b0);
        chk("p2_err_hold", 8'(err), 8'h01);

        // Short packet: len 3 but only two payload bytes, parity 0D^11^22=3E
        cyc(DECODE_ADDRESS, 1'b1, 8'h0D, 1'b0);
        chk("p3_err_clr", 8'(err), 8'h00);
        chk("p3_pd_clr", 8'(parity_done), 8'h00);
        cyc(LOAD_FIRST_DATA, 1'b1, 8'h00, 1'b0);
        cyc(LOAD_DATA, 1'b1, 8'h11, 1'b0);
        cyc(LOAD_DATA, 1'b1, 8'h22, 1'b0);
        cyc(LOAD_PARITY, 1'b0, 8'h3E, 1'b0);
        cyc(CHECK_PARITY_ERROR, 1'b0, 8'h00, 1'b0);
        chk("p3_len_err", 8'(err), 8'h01);

        // FIFO full while 0x22 is presented
        start_pkt(8'h0D);
        cyc(LOAD_DATA, 1'b1, 8'h11, 1'b0);
        cyc(LOAD_DATA, 1'b1, 8'h22, 1'b1); chk("p4_hold0", dout, 8'h11);
        cyc(FIFO_FULL_STATE, 1'b1, 8'h55, 1'b1); chk("p4_hold1", dout, 8'h11);
        cyc(LOAD_AFTER_FULL, 1'b1, 8'h77, 1'b0); chk("p4_laf", dout, 8'h22);
        cyc(LOAD_DATA, 1'b1, 8'h33, 1'b0); chk("p4_d2", dout, 8'h33);
        cyc(LOAD_PARITY, 1'b0, 8'h0D, 1'b0);
        chk("p4_pd", 8'(parity_done), 8'h01);
        cyc(CHECK_PARITY_ERROR, 1'b0, 8'h00, 1'b0);
        chk("p4_err", 8'(err), 8'h00);

        // FIFO full during the parity byte
        start_pkt(8'h0D);
        cyc(LOAD_DATA, 1'b1, 8'h11, 1'b0);
        cyc(LOAD_DATA, 1'b1, 8'h22, 1'b0);
        cyc(LOAD_DATA, 1'b1, 8'h33, 1'b0);
        cyc(LOAD_PARITY, 1'b0, 8'h0D, 1'b1);
        chk("p5_lpv", 8'(low_pkt_valid), 8'h01);
        chk("p5_pd_full", 8'(parity_done), 8'h00);
        chk("p5_dout_held", dout, 8'h33);
        cyc(FIFO_FULL_STATE, 1'b0, 8'hA5, 1'b1);
        chk("p5_pd_fs", 8'(parity_done), 8'h00);
        cyc(LOAD_AFTER_FULL, 1'b0, 8'hA5, 1'b0);
        chk("p5_pd_laf", 8'(parity_done), 8'h01);
        chk("p5_laf_dout", dout, 8'h0D);
        cyc(CHECK_PARITY_ERROR, 1'b0, 8'h00, 1'b0);
        chk("p5_lpv_clr", 8'(low_pkt_valid), 8'h00);
        chk("p5_err", 8'(err), 8'h00);

        // Asynchronous reset mid-payload, then a clean packet
        start_pkt(8'h0D);
        cyc(LOAD_DATA, 1'b1, 8'h11, 1'b0);
        cyc(LOAD_DATA, 1'b1, 8'h22, 1'b0);
        chk("p6_pre", dout, 8'h22);
        #2 reset = 1'b1;
        #1;
        chk("p6_async_dout", dout, 8'h00);
        chk("p6_async_pd", 8'(parity_done), 8'h00);
        chk("p6_async_lpv", 8'(low_pkt_valid), 8'h00);
        chk("p6_async_err", 8'(err), 8'h00);
        #1 reset = 1'b0;
        cyc(WAIT_TILL_EMPTY, 1'b0, 8'h00, 1'b0);
        start_pkt(8'h0D);
        cyc(LOAD_DATA, 1'b1, 8'h11, 1'b0);
        cyc(LOAD_DATA, 1'b1, 8'h22, 1'b0);
        cyc(LOAD_DATA, 1'b1, 8'h33, 1'b0);
        cyc(LOAD_PARITY, 1'b0, 8'h0D, 1'b0);
        chk("p6_pd", 8'(parity_done), 8'h01);
        cyc(CHECK_PARITY_ERROR, 1'b0, 8'h00, 1'b0);
        chk("p6_err", 8'(err), 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
